// File: rtl/par_serie_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : par_serie_arbiter_if
//  Purpose  : Requester/converter-side bundle of the round-robin load scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface par_serie_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 6
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] data;
    logic [NREQ-1:0]   ack;
    logic [2:0]        grant_id;
    logic              conv_ena;
    logic [W-1:0]      conv_data;
    logic              conv_busy;
    logic              busy;
    logic              err;

    // master: requesters plus converter status; slave: the arbiter itself
    modport master (
        output req, data, conv_busy,
        input  ack, grant_id, conv_ena, conv_data, busy, err
    );

    modport slave (
        input  req, data, conv_busy,
        output ack, grant_id, conv_ena, conv_data, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/par_serie_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : par_serie_arbiter
//  Purpose  : Round-robin scheduler sharing one parallel-to-serial converter.
//             Optional macro PS_ARB_TIMEOUT_EN adds a conv_busy rise timeout.
//  Revision : 1.0  initial release
// ============================================================================
module par_serie_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 6,
    parameter int TMO  = 15
) (
    input  logic               clk,
    input  logic               clr,
    par_serie_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_SHIFT     = 2'd3
    } state_t;

    localparam logic [2:0]      c_ptr_rst = 3'(NREQ - 1);
    localparam logic [NREQ-1:0] c_ack_one = {{(NREQ-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [2:0]      r_ptr;
    logic [2:0]      r_grant_id;
    logic [NREQ-1:0] r_ack;
    logic            r_conv_ena;
    logic [W-1:0]    r_conv_data;
    logic            r_busy;

    logic [W-1:0]    w_words [NREQ];
    logic [2:0]      w_grant;
    logic [W-1:0]    w_word;
    logic            w_any;

    generate
        if (NREQ < 2 || NREQ > 8 || TMO < 1) begin : g_param_check
            $error("par_serie_arbiter: NREQ must be 2..8 and TMO >= 1");
        end

        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_words[gi] = bus.data[gi*W +: W];
        end
    endgenerate

    // Rotating priority: the candidate closest after the pointer wins.
    always_comb begin
        int v_dist;
        int v_best;
        v_dist  = 0;
        v_best  = NREQ;
        w_grant = '0;
        w_word  = '0;
        w_any   = |bus.req;
        for (int i = 0; i < NREQ; i++) begin
            v_dist = (i + NREQ - 1 - int'(r_ptr)) % NREQ;
            if (bus.req[i] && (v_dist < v_best)) begin
                v_best  = v_dist;
                w_grant = 3'(i);
                w_word  = w_words[i];
            end
        end
    end

`ifdef PS_ARB_TIMEOUT_EN
    localparam int c_cnt_w = (TMO > 1) ? $clog2(TMO) : 1;

    logic [c_cnt_w-1:0] r_tmo_cnt;
    logic               r_err;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_ptr       <= c_ptr_rst;
            r_grant_id  <= '0;
            r_ack       <= '0;
            r_conv_ena  <= 1'b0;
            r_conv_data <= '0;
            r_busy      <= 1'b0;
`ifdef PS_ARB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            // load strobe, ack and data bus are single-cycle by construction
            r_ack       <= '0;
            r_conv_ena  <= 1'b0;
            r_conv_data <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state     <= S_LOAD;
                        r_ptr       <= w_grant;
                        r_grant_id  <= w_grant;
                        r_ack       <= c_ack_one << w_grant;
                        r_conv_ena  <= 1'b1;
                        r_conv_data <= w_word;
                        r_busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_WAIT_BUSY;
`ifdef PS_ARB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                S_WAIT_BUSY: begin
                    if (bus.conv_busy) begin
                        r_state <= S_SHIFT;
                    end
`ifdef PS_ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == c_cnt_w'(TMO - 1)) begin
                        // converter never started: drop the word and flag it
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                S_SHIFT: begin
                    if (!bus.conv_busy) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack       = r_ack;
    assign bus.grant_id  = r_grant_id;
    assign bus.conv_ena  = r_conv_ena;
    assign bus.conv_data = r_conv_data;
    assign bus.busy      = r_busy;
`ifdef PS_ARB_TIMEOUT_EN
    assign bus.err       = r_err;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
`default_nettype wire
